// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, imem read request, stall hold buffer, redirect and halt.
// Optional FETCH_PERF_EN adds fetch_count_o / redirect_count_o performance counters.
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK_i,
    input  logic        nRST_i,
    input  logic        ihit_i,
    input  logic [31:0] imemload_i,
    output logic        imemREN_o,
    output logic [31:0] imemaddr_o,
    output logic [31:0] instruction_o,
    output logic [31:0] next_imemaddr_o,
    output logic        fetch_valid_o,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    input  logic        halt_i
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count_o,
    output logic [31:0] redirect_count_o
`endif
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_HOLD   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_target;
    logic        unused_addr_bits;

    assign pc_plus4         = pc_q + 32'd4;
    assign redirect_target  = {redirect_addr_i[31:2], 2'b00};
    assign unused_addr_bits = ^redirect_addr_i[1:0];

    // Address outputs come from the PC register alone, never from this cycle's handshakes.
    assign imemaddr_o      = pc_q;
    assign next_imemaddr_o = pc_plus4;

    always_ff @(posedge CLK_i) begin
        if (!nRST_i) begin
            state_q <= S_FETCH;
            pc_q    <= PC_INIT;
            hold_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold_d        = hold_q;
        imemREN_o     = 1'b0;
        instruction_o = 32'h0;
        fetch_valid_o = 1'b0;

        if (nRST_i) begin
            case (state_q)
                S_FETCH: begin
                    imemREN_o     = 1'b1;
                    instruction_o = imemload_i;
                    fetch_valid_o = ihit_i & ~stall_i & ~redirect_i & ~halt_i;
                    if (ihit_i && !stall_i) begin
                        pc_d = pc_plus4;
                    end else if (ihit_i && stall_i) begin
                        hold_d  = imemload_i;
                        state_d = S_HOLD;
                    end
                end
                S_HOLD: begin
                    instruction_o = hold_q;
                    fetch_valid_o = ~stall_i & ~redirect_i & ~halt_i;
                    if (!stall_i) begin
                        pc_d    = pc_plus4;
                        state_d = S_FETCH;
                    end
                end
                default: begin
                    state_d = S_HALTED;
                end
            endcase

            // Priority: halt over redirect over the normal stall/ihit flow above.
            if (state_q != S_HALTED) begin
                if (halt_i) begin
                    pc_d    = pc_q;
                    hold_d  = hold_q;
                    state_d = S_HALTED;
                end else if (redirect_i) begin
                    pc_d    = redirect_target;
                    hold_d  = 32'h0;
                    state_d = S_FETCH;
                end
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] redirect_count_q, redirect_count_d;
    logic        redirect_taken;

    assign redirect_taken = nRST_i & redirect_i & ~halt_i & (state_q != S_HALTED);

    always_comb begin
        fetch_count_d    = fetch_count_q;
        redirect_count_d = redirect_count_q;
        if (fetch_valid_o) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
        if (redirect_taken) begin
            redirect_count_d = redirect_count_q + 32'd1;
        end
    end

    always_ff @(posedge CLK_i) begin
        if (!nRST_i) begin
            fetch_count_q    <= 32'h0;
            redirect_count_q <= 32'h0;
        end else begin
            fetch_count_q    <= fetch_count_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    assign fetch_count_o    = fetch_count_q;
    assign redirect_count_o = redirect_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven bench for fetch_unit; accepted instructions are tracked through a scoreboard queue.
// A second instance with PC_INIT=32'hFFFF_FFFC covers address wrap-around.
module tb_fetch_unit;

    logic        clk;
    logic        nrst;
    logic        ihit;
    logic [31:0] imemload;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        halt;

    logic        ren, valid;
    logic [31:0] addr, instr, naddr;
    logic        ren2, valid2;
    logic [31:0] addr2, instr2, naddr2;
`ifdef FETCH_PERF_EN
    logic [31:0] fcnt, rcnt, fcnt2, rcnt2;
`endif

    int checks   = 0;
    int failures = 0;

    fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
        .CLK_i(clk), .nRST_i(nrst), .ihit_i(ihit), .imemload_i(imemload),
        .imemREN_o(ren), .imemaddr_o(addr), .instruction_o(instr),
        .next_imemaddr_o(naddr), .fetch_valid_o(valid), .stall_i(stall),
        .redirect_i(redirect), .redirect_addr_i(redirect_addr), .halt_i(halt)
`ifdef FETCH_PERF_EN
        , .fetch_count_o(fcnt), .redirect_count_o(rcnt)
`endif
    );

    fetch_unit #(.PC_INIT(32'hFFFF_FFFC)) dut_wrap (
        .CLK_i(clk), .nRST_i(nrst), .ihit_i(ihit), .imemload_i(imemload),
        .imemREN_o(ren2), .imemaddr_o(addr2), .instruction_o(instr2),
        .next_imemaddr_o(naddr2), .fetch_valid_o(valid2), .stall_i(stall),
        .redirect_i(redirect), .redirect_addr_i(redirect_addr), .halt_i(halt)
`ifdef FETCH_PERF_EN
        , .fetch_count_o(fcnt2), .redirect_count_o(rcnt2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        nrst, ihit;
        logic [31:0] load;
        logic        stall, redir;
        logic [31:0] raddr;
        logic        halt;
        logic        e_ren, chk_addr;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
    } acc_t;

    vec_t vecs[$];
    acc_t sb[$];

    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    function automatic logic [31:0] w(input logic [31:0] a);
        return 32'h1357_0000 ^ a;
    endfunction

    function automatic vec_t mk(input logic n, input logic h, input logic [31:0] ld,
                                input logic s, input logic r, input logic [31:0] ra,
                                input logic hl, input logic er, input logic ca,
                                input logic [31:0] ea, input logic ev, input logic [31:0] ei);
        vec_t v;
        v.nrst = n; v.ihit = h; v.load = ld; v.stall = s; v.redir = r; v.raddr = ra;
        v.halt = hl; v.e_ren = er; v.chk_addr = ca; v.e_addr = ea; v.e_valid = ev;
        v.e_instr = ei;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drive(input logic n, input logic h, input logic [31:0] ld, input logic s,
                         input logic r, input logic [31:0] ra, input logic hl);
        nrst = n; ihit = h; imemload = ld; stall = s; redirect = r; redirect_addr = ra; halt = hl;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

        // reset and straight-line fetch
        vecs.push_back(mk(0,1,w(0),0,0,0,0,        0,0,32'h0,  0,32'h0));
        vecs.push_back(mk(0,1,w(0),0,0,0,0,        0,1,32'h0,  0,32'h0));
        vecs.push_back(mk(1,1,w(0),0,0,0,0,        1,1,32'h0,  1,w(0)));
        vecs.push_back(mk(1,1,w(4),0,0,0,0,        1,1,32'h4,  1,w(4)));
        vecs.push_back(mk(1,1,w(8),0,0,0,0,        1,1,32'h8,  1,w(8)));
        vecs.push_back(mk(1,1,w(12),0,0,0,0,       1,1,32'hC,  1,w(12)));
        // stall captures word into HOLD, released after three stall cycles
        vecs.push_back(mk(1,1,w(16),1,0,0,0,       1,1,32'h10, 0,w(16)));
        vecs.push_back(mk(1,0,JUNK,1,0,0,0,        0,1,32'h10, 0,w(16)));
        vecs.push_back(mk(1,0,JUNK,1,0,0,0,        0,1,32'h10, 0,w(16)));
        vecs.push_back(mk(1,0,JUNK,0,0,0,0,        0,1,32'h10, 1,w(16)));
        vecs.push_back(mk(1,0,JUNK,0,0,0,0,        1,1,32'h14, 0,JUNK));
        // redirect with ihit drops the word; redirect in HOLD discards the held word
        vecs.push_back(mk(1,1,w(20),0,1,32'h103,0, 1,1,32'h14, 0,w(20)));
        vecs.push_back(mk(1,1,w(256),1,0,0,0,      1,1,32'h100,0,w(256)));
        vecs.push_back(mk(1,0,JUNK,1,1,32'h200,0,  0,1,32'h100,0,w(256)));
        vecs.push_back(mk(1,0,JUNK,0,0,0,0,        1,1,32'h200,0,JUNK));
        vecs.push_back(mk(1,1,w(512),0,0,0,0,      1,1,32'h200,1,w(512)));
        // halt beats redirect; HALTED ignores everything until reset
        vecs.push_back(mk(1,1,w(516),0,1,32'h300,1,1,1,32'h204,0,w(516)));
        vecs.push_back(mk(1,1,w(516),0,1,32'h400,0,0,1,32'h204,0,32'h0));
        vecs.push_back(mk(1,1,w(516),0,0,0,0,      0,1,32'h204,0,32'h0));
        vecs.push_back(mk(0,1,w(516),0,0,0,0,      0,1,32'h204,0,32'h0));
        vecs.push_back(mk(1,1,w(0),0,0,0,0,        1,1,32'h0,  1,w(0)));
        // reset while stalled in HOLD
        vecs.push_back(mk(1,1,w(4),1,0,0,0,        1,1,32'h4,  0,w(4)));
        vecs.push_back(mk(0,0,JUNK,1,0,0,0,        0,1,32'h4,  0,32'h0));
        vecs.push_back(mk(1,0,JUNK,1,0,0,0,        1,1,32'h0,  0,JUNK));
        vecs.push_back(mk(1,1,w(0),0,0,0,0,        1,1,32'h0,  1,w(0)));

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            drive(v.nrst, v.ihit, v.load, v.stall, v.redir, v.raddr, v.halt);
            if (v.e_valid) begin
                acc_t a;
                a.addr  = v.e_addr;
                a.instr = v.e_instr;
                sb.push_back(a);
            end
            #3;
            check($sformatf("v%0d_ren", i), {31'h0, ren}, {31'h0, v.e_ren});
            check($sformatf("v%0d_valid", i), {31'h0, valid}, {31'h0, v.e_valid});
            check($sformatf("v%0d_instr", i), instr, v.e_instr);
            if (v.chk_addr) begin
                check($sformatf("v%0d_addr", i), addr, v.e_addr);
                check($sformatf("v%0d_naddr", i), naddr, v.e_addr + 32'd4);
            end
            if (valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL v%0d_sb unexpected fetch got=%h exp=none", i, instr);
                end else begin
                    acc_t a;
                    a = sb.pop_front();
                    check($sformatf("v%0d_sb_addr", i), addr, a.addr);
                    check($sformatf("v%0d_sb_instr", i), instr, a.instr);
                end
            end
            $display("vec %0d nrst=%0b ihit=%0b stall=%0b redir=%0b halt=%0b -> ren=%0b addr=%h valid=%0b instr=%h",
                     i, v.nrst, v.ihit, v.stall, v.redir, v.halt, ren, addr, valid, instr);
            next_cycle();
        end
        check("sb_drained", sb.size(), 32'd0);

        // counters after reset-in-HOLD, then a lone redirect
`ifdef FETCH_PERF_EN
        check("perf_fetch_after_reset", fcnt, 32'd1);
        check("perf_redir_after_reset", rcnt, 32'd0);
`endif
        drive(1'b1, 1'b0, JUNK, 1'b0, 1'b1, 32'h0000_0041, 1'b0);
        #3;
        check("redir_lone_valid", {31'h0, valid}, 32'h0);
        next_cycle();
        drive(1'b1, 1'b0, JUNK, 1'b0, 1'b0, 32'h0, 1'b0);
        #3;
        check("redir_lone_addr", addr, 32'h40);
`ifdef FETCH_PERF_EN
        check("perf_redir_count", rcnt, 32'd1);
        check("perf_fetch_hold", fcnt, 32'd1);
`endif
        $display("txn redirect 0x41 -> addr=%h", addr);
        next_cycle();

        // wrap-around on the PC_INIT=FFFF_FFFC instance
        drive(1'b0, 1'b0, JUNK, 1'b0, 1'b0, 32'h0, 1'b0);
        next_cycle();
        drive(1'b1, 1'b1, 32'hCAFE_0001, 1'b0, 1'b0, 32'h0, 1'b0);
        #3;
        check("wrap_addr", addr2, 32'hFFFF_FFFC);
        check("wrap_naddr", naddr2, 32'h0);
        check("wrap_valid", {31'h0, valid2}, 32'h1);
        check("wrap_instr", instr2, 32'hCAFE_0001);
        $display("txn wrap addr=%h next=%h valid=%0b", addr2, naddr2, valid2);
        next_cycle();
        drive(1'b1, 1'b0, JUNK, 1'b0, 1'b0, 32'h0, 1'b0);
        #3;
        check("wrap_addr_after", addr2, 32'h0);
        check("wrap_naddr_after", naddr2, 32'h4);
        $display("txn wrap follow addr=%h next=%h", addr2, naddr2);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
